wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between two writers: the in-order pipeline writeback stage and the multicycle mult/div unit.
- Buffers mult/div results in a small FIFO and grants the port to them only on cycles with no pipeline write.
- Escalates to a pipeline stall request when a buffered result starves.
- Keeps a per-register pending scoreboard so decode can detect RAW hazards on outstanding mult/div destinations.

Parameters:
- DATA_W, 32, write data width.
- REG_AW, 5, register address width; 2**REG_AW registers.
- DEPTH, 2, mult/div result FIFO entries; legal range 2..8.
- STARVE_MAX, 4, cycles the FIFO head may wait before stall_req asserts; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- p_we  in  1  pipeline writeback valid; cannot be back-pressured.
- p_reg  in  REG_AW  pipeline destination register.
- p_data  in  DATA_W  pipeline write data.
- m_valid  in  1  mult/div result valid.
- m_ready  out  1  FIFO can accept a result.
- m_reg  in  REG_AW  mult/div destination register.
- m_data  in  DATA_W  mult/div result.
- issue_valid  in  1  decode issues a mult/div op this cycle.
- issue_reg  in  REG_AW  destination of the issued op.
- issue_ok  out  1  issue_reg not pending; combinational.
- q_reg1, q_reg2  in  REG_AW  decode source registers.
- q_haz1, q_haz2  out  1  source is pending; combinational.
- stall_req  out  1  request that upstream inject a bubble.
- regWrite  out  1  register file write enable; registered.
- writeReg  out  REG_AW  register file write address; registered.
- writeData  out  DATA_W  register file write data; registered.

Behaviour:
Reset (rst=0 at a rising edge):
- regWrite=0, writeReg=0, writeData=0, stall_req=0.
- FIFO flushed, scoreboard cleared, starve counter=0, FSM=S_IDLE.
- Any in-flight data is dropped.

Timing:
- Inputs are sampled at rising edge k; the write outputs update at edge k.
- The register file commits at the falling edge after edge k.

Pipeline requests:
- An effective pipeline request is p_we=1 and p_reg!=0; p_reg=0 counts as no request.
- An effective pipeline request always wins and drives the outputs: regWrite=1, writeReg=p_reg, writeData=p_data.
- With no effective pipeline request and the FIFO non-empty, the FIFO head is popped and written.
- Otherwise regWrite=0, and writeReg/writeData hold their previous values.

Mult/div FIFO:
- m_ready = (count < DEPTH). It is computed from current state only; there is no bypass.
- A push at edge k makes the entry eligible for a grant no earlier than edge k+1.
- A result with m_reg=0 is accepted on handshake and discarded without being stored.
- Simultaneous push and pop: count is unchanged.
- When full, m_ready=0 even if a pop happens in the same cycle.

Scoreboard (one busy bit per register):
- An issue sets the bit when issue_valid=1 and issue_reg!=0.
- The bit clears when a FIFO entry for that register is granted.
- Set and clear of the same register in the same cycle: set wins.
- issue_ok = !busy[issue_reg]. Issuing while busy is a protocol error: busy stays set and there is no other effect.
- q_hazN = busy[q_regN]; always 0 for register 0.
- A pipeline write to a busy register is performed; busy is unchanged.

FSM:
- S_IDLE: FIFO empty; counter=0. Goes to S_PEND when count becomes non-zero.
- S_PEND: FIFO non-empty.
  - On a head grant: counter=0; go to S_IDLE if the FIFO is now empty, else stay.
  - On a denial: counter+1. When the counter reaches STARVE_MAX, go to S_FORCE.
- S_FORCE: stall_req=1 (registered, asserted on the transition edge).
  - On a head grant: stall_req=0, counter=0, go to S_PEND or S_IDLE.
- stall_req drops at the same edge as the grant.

Decomposition:
- Shared package pipeline_pkg: REG_AW, DATA_W, REG_ZERO constant, arbiter state enum (S_IDLE, S_PEND, S_FORCE).
- One sub-module, wb_fifo: synchronous FIFO.
  - Parameters: width REG_AW+DATA_W, DEPTH.
  - Ports: push/pop/full/empty/count, synchronous active-low reset.
- Arbitration, FSM and scoreboard stay in the top module.

Test Plan:
1. Reset and idle: hold rst=0 for 2 cycles with inputs active, then release and stay idle -> regWrite=0, m_ready=1, stall_req=0, all q_haz=0.
2. Priority: at the same edge push m(r7,0xAA); p_we(r3,0x11) for 2 cycles, then idle.
   - Grant sequence r3/0x11, r3/0x11, then r7/0xAA.
   - busy[7] clears on r7's grant.
3. FIFO full: push r8, r9 with p_we held high (DEPTH=2) -> m_ready=0. Drop p_we -> r8, then r9 written in order, and m_ready=1 one edge after the first pop.
4. Starvation: push r5 with p_we continuous.
   - stall_req rises after 4 denials.
   - Drop p_we one cycle -> r5 written and stall_req=0 at that edge.
5. r0 handling:
   - p_we(r0,0x55) with the FIFO holding r6 -> r6 written that cycle.
   - m(r0,0x99) accepted, never written, and count unchanged.
6. Scoreboard:
   - issue r4 -> q_haz1=1 for q_reg1=4 and issue_ok=0 for issue_reg=4.
   - Grant of r4 together with issue_valid(r4) in the same cycle -> busy[4] stays 1.
   - rst=0 mid-stream -> busy cleared and FIFO empty.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   REG_AW / DATA_W : default register address and data widths
//   REG_ZERO        : architectural zero register (writes to it are dropped)
//   arb_state_e     : mult/div starvation FSM states
package pipeline_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_FORCE
  } arb_state_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the writeback, mult/div, decode-query and register-file signals
// around wb_port_arbiter.
//   slave  : arbiter side (consumes requests, drives grants/hazards)
//   master : environment side (pipeline, mult/div unit, decode, regfile)
interface wb_port_arbiter_if #(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int REG_AW = pipeline_pkg::REG_AW
);
  logic              p_we;
  logic [REG_AW-1:0] p_reg;
  logic [DATA_W-1:0] p_data;
  logic              m_valid;
  logic              m_ready;
  logic [REG_AW-1:0] m_reg;
  logic [DATA_W-1:0] m_data;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_reg;
  logic              issue_ok;
  logic [REG_AW-1:0] q_reg1;
  logic [REG_AW-1:0] q_reg2;
  logic              q_haz1;
  logic              q_haz2;
  logic              stall_req;
  logic              regWrite;
  logic [REG_AW-1:0] writeReg;
  logic [DATA_W-1:0] writeData;

  modport slave (
    input  p_we, p_reg, p_data, m_valid, m_reg, m_data,
           issue_valid, issue_reg, q_reg1, q_reg2,
    output m_ready, issue_ok, q_haz1, q_haz2, stall_req,
           regWrite, writeReg, writeData
  );

  modport master (
    output p_we, p_reg, p_data, m_valid, m_reg, m_data,
           issue_valid, issue_reg, q_reg1, q_reg2,
    input  m_ready, issue_ok, q_haz1, q_haz2, stall_req,
           regWrite, writeReg, writeData
  );
endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// wb_fifo: synchronous FIFO buffering mult/div results.
//   clk, rst     : clock, synchronous active-low reset
//   push / wdata : write an entry (ignored when full)
//   pop  / rdata : rdata is the head; pop removes it (ignored when empty)
//   full, empty, count : occupancy from current state only
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// writeback stage (always wins) and buffered mult/div results (granted on
// idle cycles). Escalates to stall_req when a buffered result starves, and
// tracks outstanding mult/div destinations for decode hazard checks.
//   clk, rst : clock, synchronous active-low reset
//   bus      : wb_port_arbiter_if.slave (requests, hazards, regfile write)
module wb_port_arbiter #(
  parameter int DATA_W     = pipeline_pkg::DATA_W,
  parameter int REG_AW     = pipeline_pkg::REG_AW,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);
  import pipeline_pkg::*;

  localparam int FW    = REG_AW + DATA_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 2 ** REG_AW;

  logic [FW-1:0]     fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_pop, m_push, p_eff;
  logic [CNT_W-1:0]  fifo_count, cnt_after;
  logic [REG_AW-1:0] head_reg;
  logic [DATA_W-1:0] head_data;

  arb_state_e        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              stall_q, stall_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              regwrite_q, regwrite_d;
  logic [REG_AW-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  assign p_eff    = bus.p_we && (bus.p_reg != REG_AW'(REG_ZERO));
  // Results for r0 complete the handshake but are never stored.
  assign m_push   = bus.m_valid && !fifo_full && (bus.m_reg != REG_AW'(REG_ZERO));
  assign fifo_pop = !p_eff && !fifo_empty;
  assign head_reg  = fifo_rdata[FW-1 -: REG_AW];
  assign head_data = fifo_rdata[DATA_W-1:0];
  assign cnt_after = fifo_count + CNT_W'(m_push) - CNT_W'(fifo_pop);

  wb_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (m_push),
    .wdata ({bus.m_reg, bus.m_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.m_ready   = !fifo_full;
  assign bus.issue_ok  = !busy_q[bus.issue_reg];
  assign bus.q_haz1    = busy_q[bus.q_reg1];
  assign bus.q_haz2    = busy_q[bus.q_reg2];
  assign bus.stall_req = stall_q;
  assign bus.regWrite  = regwrite_q;
  assign bus.writeReg  = wreg_q;
  assign bus.writeData = wdata_q;

  always_comb begin
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (p_eff) begin
      regwrite_d = 1'b1;
      wreg_d     = bus.p_reg;
      wdata_d    = bus.p_data;
    end else if (!fifo_empty) begin
      regwrite_d = 1'b1;
      wreg_d     = head_reg;
      wdata_d    = head_data;
    end
  end

  // Clear on grant first so a same-cycle issue of that register re-sets it.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) busy_d[head_reg] = 1'b0;
    if (bus.issue_valid && (bus.issue_reg != REG_AW'(REG_ZERO)))
      busy_d[bus.issue_reg] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    stall_d  = stall_q;
    case (state_q)
      S_IDLE: begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (cnt_after != '0) state_d = S_PEND;
      end
      S_PEND: begin
        if (fifo_pop) begin
          starve_d = '0;
          if (cnt_after == '0) state_d = S_IDLE;
        end else begin
          starve_d = starve_q + 1'b1;
          if (starve_d == 4'(STARVE_MAX)) begin
            state_d = S_FORCE;
            stall_d = 1'b1;
          end
        end
      end
      S_FORCE: begin
        if (fifo_pop) begin
          starve_d = '0;
          stall_d  = 1'b0;
          state_d  = (cnt_after == '0) ? S_IDLE : S_PEND;
        end
      end
      default: begin
        state_d  = S_IDLE;
        starve_d = '0;
        stall_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      busy_q     <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      busy_q     <= busy_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  wb_port_arbiter_if #(.DATA_W(32), .REG_AW(5)) bus ();

  wb_port_arbiter #(.DATA_W(32), .REG_AW(5), .DEPTH(2), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        p_we;
    logic [4:0]  p_reg;
    logic [31:0] p_data;
    logic        m_valid;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic        iv;
    logic [4:0]  ireg;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_rdy;
    logic        e_h1;
    logic        e_h2;
    logic        e_ok;
    logic        e_rw;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    logic        e_stall;
  } vec_t;

  localparam int NV = 23;
  vec_t tv [NV];

  function automatic vec_t mk(
    input logic pw, input logic [4:0] pr, input logic [31:0] pd,
    input logic mv, input logic [4:0] mr, input logic [31:0] md,
    input logic iv, input logic [4:0] ir, input logic [4:0] q1, input logic [4:0] q2,
    input logic rdy, input logic h1, input logic h2, input logic ok,
    input logic rw, input logic [4:0] wr, input logic [31:0] wd, input logic st);
    vec_t v;
    v.p_we = pw; v.p_reg = pr; v.p_data = pd;
    v.m_valid = mv; v.m_reg = mr; v.m_data = md;
    v.iv = iv; v.ireg = ir; v.q1 = q1; v.q2 = q2;
    v.e_rdy = rdy; v.e_h1 = h1; v.e_h2 = h2; v.e_ok = ok;
    v.e_rw = rw; v.e_wreg = wr; v.e_wdata = wd; v.e_stall = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.p_we = v.p_we; bus.p_reg = v.p_reg; bus.p_data = v.p_data;
    bus.m_valid = v.m_valid; bus.m_reg = v.m_reg; bus.m_data = v.m_data;
    bus.issue_valid = v.iv; bus.issue_reg = v.ireg;
    bus.q_reg1 = v.q1; bus.q_reg2 = v.q2;
  endtask

  task automatic idle_inputs();
    drive(mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0,0));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //        p_we,reg,data     m_v,reg,data      iv,ireg q1,q2  rdy,h1,h2,ok  rw,wreg,wdata   stall
    tv[0]  = mk(0,0,0,          0,0,0,            0,0,    0,0,   1,0,0,1,      0,0,0,          0);
    tv[1]  = mk(0,0,0,          0,0,0,            1,7,    7,3,   1,0,0,1,      0,0,0,          0);
    tv[2]  = mk(1,3,32'h11,     1,7,32'hAA,       0,7,    7,3,   1,1,0,0,      1,3,32'h11,     0);
    tv[3]  = mk(1,3,32'h11,     0,0,0,            0,7,    7,3,   1,1,0,0,      1,3,32'h11,     0);
    tv[4]  = mk(0,0,0,          0,0,0,            0,7,    7,3,   1,1,0,0,      1,7,32'hAA,     0);
    tv[5]  = mk(0,0,0,          0,0,0,            0,7,    7,3,   1,0,0,1,      0,7,32'hAA,     0);
    tv[6]  = mk(0,0,0,          0,0,0,            1,8,    8,9,   1,0,0,1,      0,7,32'hAA,     0);
    tv[7]  = mk(1,1,32'h01,     1,8,32'h88,       1,9,    8,9,   1,1,0,1,      1,1,32'h01,     0);
    tv[8]  = mk(1,1,32'h02,     1,9,32'h99,       0,9,    8,9,   1,1,1,0,      1,1,32'h02,     0);
    tv[9]  = mk(1,1,32'h03,     1,10,32'hA0,      0,9,    8,9,   0,1,1,0,      1,1,32'h03,     0);
    tv[10] = mk(0,0,0,          1,10,32'hA0,      0,9,    8,9,   0,1,1,0,      1,8,32'h88,     0);
    tv[11] = mk(0,0,0,          0,0,0,            0,9,    8,9,   1,0,1,0,      1,9,32'h99,     0);
    tv[12] = mk(0,0,0,          0,0,0,            0,9,    8,9,   1,0,0,1,      0,9,32'h99,     0);
    tv[13] = mk(0,0,0,          1,6,32'h66,       0,0,    0,0,   1,0,0,1,      0,9,32'h99,     0);
    tv[14] = mk(1,0,32'h55,     0,0,0,            0,0,    0,0,   1,0,0,1,      1,6,32'h66,     0);
    tv[15] = mk(0,0,0,          1,0,32'h99,       0,0,    0,0,   1,0,0,1,      0,6,32'h66,     0);
    tv[16] = mk(0,0,0,          0,0,0,            0,0,    0,0,   1,0,0,1,      0,6,32'h66,     0);
    tv[17] = mk(0,0,0,          0,0,0,            1,4,    4,0,   1,0,0,1,      0,6,32'h66,     0);
    tv[18] = mk(0,0,0,          1,4,32'h44,       1,4,    4,0,   1,1,0,0,      0,6,32'h66,     0);
    tv[19] = mk(0,0,0,          0,0,0,            1,4,    4,0,   1,1,0,0,      1,4,32'h44,     0);
    tv[20] = mk(0,0,0,          0,0,0,            0,4,    4,0,   1,1,0,0,      0,4,32'h44,     0);
    tv[21] = mk(1,4,32'h40,     0,0,0,            0,4,    4,0,   1,1,0,0,      1,4,32'h40,     0);
    tv[22] = mk(0,0,0,          0,0,0,            0,4,    4,0,   1,1,0,0,      0,4,32'h40,     0);

    // Reset held for two edges with every request active.
    rst = 1'b0;
    drive(mk(1,3,32'h11, 1,7,32'hAA, 1,4, 4,7, 0,0,0,0, 0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset regWrite", bus.regWrite, 0);
    chk("reset writeReg", bus.writeReg, 0);
    chk("reset writeData", bus.writeData, 0);
    chk("reset stall_req", bus.stall_req, 0);
    rst = 1'b1;
    idle_inputs();
    bus.q_reg1 = 5'd4;
    bus.q_reg2 = 5'd7;
    #1;
    chk("reset m_ready", bus.m_ready, 1);
    chk("reset q_haz1", bus.q_haz1, 0);
    chk("reset q_haz2", bus.q_haz2, 0);

    // Table: combinational outputs checked before the edge, registered after.
    for (int i = 0; i < NV; i++) begin
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d m_ready", i), bus.m_ready, tv[i].e_rdy);
      chk($sformatf("v%0d q_haz1", i), bus.q_haz1, tv[i].e_h1);
      chk($sformatf("v%0d q_haz2", i), bus.q_haz2, tv[i].e_h2);
      chk($sformatf("v%0d issue_ok", i), bus.issue_ok, tv[i].e_ok);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d regWrite", i), bus.regWrite, tv[i].e_rw);
      chk($sformatf("v%0d writeReg", i), bus.writeReg, tv[i].e_wreg);
      chk($sformatf("v%0d writeData", i), bus.writeData, tv[i].e_wdata);
      chk($sformatf("v%0d stall_req", i), bus.stall_req, tv[i].e_stall);
    end

    // Starvation: r5 buffered while the pipeline writes every cycle.
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      bus.p_we = 1'b1;
      bus.p_reg = 5'd2;
      bus.p_data = 32'(i);
      bus.m_valid = (i == 0);
      bus.m_reg = 5'd5;
      bus.m_data = 32'h55;
      @(posedge clk);
      #1;
      chk($sformatf("starve%0d stall_req", i), bus.stall_req, (i >= 4));
      chk($sformatf("starve%0d writeReg", i), bus.writeReg, 2);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    chk("starve grant regWrite", bus.regWrite, 1);
    chk("starve grant writeReg", bus.writeReg, 5);
    chk("starve grant writeData", bus.writeData, 32'h55);
    chk("starve grant stall_req", bus.stall_req, 0);
    @(posedge clk);
    #1;
    chk("starve after regWrite", bus.regWrite, 0);
    chk("starve after stall_req", bus.stall_req, 0);

    // Reset mid-stream: r12 buffered and pending, r4 still pending.
    drive(mk(1,2,32'h77, 1,12,32'hC0, 1,12, 12,4, 0,0,0,0, 0,0,0,0));
    @(posedge clk);
    #1;
    idle_inputs();
    bus.q_reg1 = 5'd12;
    bus.q_reg2 = 5'd4;
    #1;
    chk("pre-rst q_haz1", bus.q_haz1, 1);
    chk("pre-rst q_haz2", bus.q_haz2, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst regWrite", bus.regWrite, 0);
    chk("midrst writeReg", bus.writeReg, 0);
    chk("midrst writeData", bus.writeData, 0);
    chk("midrst q_haz1", bus.q_haz1, 0);
    chk("midrst q_haz2", bus.q_haz2, 0);
    rst = 1'b1;
    bus.issue_reg = 5'd12;
    #1;
    chk("midrst issue_ok", bus.issue_ok, 1);
    chk("midrst m_ready", bus.m_ready, 1);
    @(posedge clk);
    #1;
    chk("midrst fifo empty regWrite", bus.regWrite, 0);
    chk("midrst stall_req", bus.stall_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
